// File: rtl/rtc_pkg.sv
// Shared types and helpers for the time-of-day core: edit field encoding,
// window decimal-point patterns and a small binary-to-BCD converter.
package rtc_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOUR = 2'd1,
        MIN  = 2'd2,
        SEC  = 2'd3
    } field_e;

    localparam logic [3:0] DP_OUTER = 4'b1010;
    localparam logic [3:0] DP_INNER = 4'b0101;

    // Converts 0..59 into two BCD nibbles {tens, units}.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] units;
        tens  = 4'(v / 6'd10);
        units = v - 6'(tens) * 6'd10;
        return {tens, 4'(units)};
    endfunction

endpackage

// File: rtl/rtc_btn_holdoff.sv
// Button front end: 2-flop synchroniser plus a hold-off counter that turns
// a held level into a press pulse every time the counter drains to zero.
module rtc_btn_holdoff #(
    parameter int unsigned HOLD_CYC = 25000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_c
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    assign press_c = sync_q[1] && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
            if (press_c) begin
                cnt_q <= CNT_W'(HOLD_CYC);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day core: seconds divider, HH:MM:SS counters, button field editing
// and a sliding 4-digit window. Define HOUR12_EN for the 12-hour display option.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned DIV0     = 50000000,
    parameter int unsigned DIV1     = 1000000,
    parameter int unsigned DIV2     = 83333,
    parameter int unsigned DIV3     = 400,
    parameter int unsigned HOLD_CYC = 25000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  speed,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_left,
    input  logic        btn_right,
`ifdef HOUR12_EN
    input  logic        mode_12h,
    output logic        pm,
`endif
    output logic [7:0]  hour_bcd,
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic [15:0] disp_digits,
    output logic [3:0]  dp_mask,
    output logic [3:0]  blink_mask,
    output logic [1:0]  edit_field,
    output logic [1:0]  win_off,
    output logic        sec_tick,
    output logic [7:0]  led_bar
);

    logic mode_p_c, inc_p_c, left_p_c, right_p_c;

    rtc_btn_holdoff #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_mode (
        .clk(clk), .rst(rst), .btn(btn_mode), .press_c(mode_p_c));
    rtc_btn_holdoff #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_inc (
        .clk(clk), .rst(rst), .btn(btn_inc), .press_c(inc_p_c));
    rtc_btn_holdoff #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_left (
        .clk(clk), .rst(rst), .btn(btn_left), .press_c(left_p_c));
    rtc_btn_holdoff #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_right (
        .clk(clk), .rst(rst), .btn(btn_right), .press_c(right_p_c));

    field_e           field_q, field_d;
    logic [4:0]       h_q, h_d;
    logic [5:0]       m_q, m_d, s_q, s_d;
    logic [1:0]       win_q, win_d;
    logic [CNT_W-1:0] div_q, div_d, div_lim_c;
    logic             tick_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            field_q <= RUN;
            h_q     <= '0;
            m_q     <= '0;
            s_q     <= '0;
            win_q   <= '0;
            div_q   <= '0;
        end else begin
            field_q <= field_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            win_q   <= win_d;
            div_q   <= div_d;
        end
    end

    // Edit field sequencing on each accepted mode press.
    always_comb begin
        field_d = field_q;
        if (mode_p_c) begin
            case (field_q)
                RUN:     field_d = HOUR;
                HOUR:    field_d = MIN;
                MIN:     field_d = SEC;
                default: field_d = RUN;
            endcase
        end
    end

    always_comb begin
        case (speed)
            2'd0:    div_lim_c = CNT_W'(DIV0 - 1);
            2'd1:    div_lim_c = CNT_W'(DIV1 - 1);
            2'd2:    div_lim_c = CNT_W'(DIV2 - 1);
            default: div_lim_c = CNT_W'(DIV3 - 1);
        endcase
    end

    // >= rather than == lets a speed change past the limit tick immediately.
    assign tick_c = (field_q != SEC) && (div_q >= div_lim_c);

    always_comb begin
        div_d = div_q + CNT_W'(1);
        if ((field_q == SEC) || tick_c) begin
            div_d = '0;
        end
    end

    // Tick carry chain first, then the field increment on top of its result.
    always_comb begin
        h_d = h_q;
        m_d = m_q;
        s_d = s_q;
        if (tick_c) begin
            if (s_q == 6'd59) begin
                s_d = '0;
                if (m_q == 6'd59) begin
                    m_d = '0;
                    h_d = (h_q == 5'd23) ? '0 : h_q + 5'd1;
                end else begin
                    m_d = m_q + 6'd1;
                end
            end else begin
                s_d = s_q + 6'd1;
            end
        end
        if (inc_p_c) begin
            case (field_q)
                HOUR:    h_d = (h_d == 5'd23) ? '0 : h_d + 5'd1;
                MIN:     m_d = (m_d == 6'd59) ? '0 : m_d + 6'd1;
                SEC:     s_d = (s_d == 6'd59) ? '0 : s_d + 6'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        win_d = win_q;
        if (right_p_c && !left_p_c && (win_q != 2'd2)) begin
            win_d = win_q + 2'd1;
        end else if (left_p_c && !right_p_c && (win_q != 2'd0)) begin
            win_d = win_q - 2'd1;
        end
    end

    logic [4:0]  hdisp_c;
    logic [7:0]  hb_c, mb_c, sb_c, led_c, dig_fld_c;
    logic [15:0] digits_c;
    logic [3:0]  dp_c, blink_c;

    always_comb begin
        hdisp_c = h_q;
`ifdef HOUR12_EN
        if (mode_12h) begin
            if (h_q == 5'd0) begin
                hdisp_c = 5'd12;
            end else if (h_q > 5'd12) begin
                hdisp_c = h_q - 5'd12;
            end
        end
`endif
        hb_c = bin_to_bcd(6'(hdisp_c));
        mb_c = bin_to_bcd(m_q);
        sb_c = bin_to_bcd(s_q);
    end

    // Window select; dig_fld_c tags each visible digit with its owning field.
    always_comb begin
        case (win_q)
            2'd0: begin
                digits_c  = {hb_c, mb_c};
                dp_c      = DP_OUTER;
                dig_fld_c = {HOUR, HOUR, MIN, MIN};
            end
            2'd1: begin
                digits_c  = {hb_c[3:0], mb_c, sb_c[7:4]};
                dp_c      = DP_INNER;
                dig_fld_c = {HOUR, MIN, MIN, SEC};
            end
            default: begin
                digits_c  = {mb_c, sb_c};
                dp_c      = DP_OUTER;
                dig_fld_c = {MIN, MIN, SEC, SEC};
            end
        endcase
        blink_c = '0;
        for (int i = 0; i < 4; i++) begin
            blink_c[i] = (field_q != RUN) && (dig_fld_c[2*i +: 2] == field_q);
        end
    end

    assign led_c = {s_q[0], 1'b0, s_q > 6'd5, s_q > 6'd15, s_q > 6'd25,
                    s_q > 6'd35, s_q > 6'd45, s_q > 6'd55};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_bcd    <= '0;
            min_bcd     <= '0;
            sec_bcd     <= '0;
            disp_digits <= '0;
            dp_mask     <= '0;
            blink_mask  <= '0;
            edit_field  <= '0;
            win_off     <= '0;
            sec_tick    <= 1'b0;
            led_bar     <= '0;
`ifdef HOUR12_EN
            pm          <= 1'b0;
`endif
        end else begin
            hour_bcd    <= hb_c;
            min_bcd     <= mb_c;
            sec_bcd     <= sb_c;
            disp_digits <= digits_c;
            dp_mask     <= dp_c;
            blink_mask  <= blink_c;
            edit_field  <= field_q;
            win_off     <= win_q;
            sec_tick    <= tick_c;
            led_bar     <= led_c;
`ifdef HOUR12_EN
            pm          <= (h_q >= 5'd12);
`endif
        end
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with short divisors and hold-off;
// expected values are queued when stimulus is applied and popped at check time.
module tb_rtc_timekeeper;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  speed = 2'd0;
    logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [7:0]  hour_bcd, min_bcd, sec_bcd, led_bar;
    logic [15:0] disp_digits;
    logic [3:0]  dp_mask, blink_mask;
    logic [1:0]  edit_field, win_off;
    logic        sec_tick;
`ifdef HOUR12_EN
    logic        mode_12h = 1'b0;
    logic        pm;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int tick_cnt = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  hexp_q[$];

    rtc_timekeeper #(
        .DIV0(100000), .DIV1(20), .DIV2(10), .DIV3(2),
        .HOLD_CYC(HOLD), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .speed(speed),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_left(btn_left), .btn_right(btn_right),
`ifdef HOUR12_EN
        .mode_12h(mode_12h), .pm(pm),
`endif
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .disp_digits(disp_digits), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .edit_field(edit_field), .win_off(win_off),
        .sec_tick(sec_tick), .led_bar(led_bar)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sec_tick === 1'b1) tick_cnt = tick_cnt + 1;
    end

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] exp_led(input int s);
        logic [7:0] r;
        r = '0;
        r[7] = ((s % 2) == 1);
        for (int k = 0; k < 6; k++) r[5-k] = (s > 5 + 10 * k);
        return r;
    endfunction

    // Buttons {mode, inc, left, right}: two sampled cycles high, then idle past hold-off.
    task automatic press(input logic [3:0] b);
        @(negedge clk);
        {btn_mode, btn_inc, btn_left, btn_right} = b;
        repeat (2) @(negedge clk);
        {btn_mode, btn_inc, btn_left, btn_right} = 4'b0000;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h0) begin
            n_fail++; $display("FAIL reset_time: got %h expected 000000", {hour_bcd, min_bcd, sec_bcd});
        end
        n_chk++;
        if ({disp_digits, dp_mask, blink_mask} !== 24'h0) begin
            n_fail++; $display("FAIL reset_window: got %h expected 000000", {disp_digits, dp_mask, blink_mask});
        end
        n_chk++;
        if ({edit_field, win_off, sec_tick, led_bar} !== 13'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected 0000", {edit_field, win_off, sec_tick, led_bar});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_rollover();
        logic [23:0] exp;
        int t0;
        press(4'b1000); repeat (23) press(4'b0100);
        press(4'b1000); repeat (59) press(4'b0100);
        press(4'b1000); repeat (59) press(4'b0100);
        press(4'b1000);
        exp_q.push_back({bcd(23), bcd(59), bcd(59)});
        exp = exp_q.pop_front();
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd} !== exp || edit_field !== 2'd0) begin
            n_fail++; $display("FAIL preset_235959: got %h field %0d expected %h field 0",
                               {hour_bcd, min_bcd, sec_bcd}, edit_field, exp);
        end
        // One cycle at the fast divisor with the divider already past its limit = one tick.
        t0 = tick_cnt;
        @(negedge clk);
        speed = 2'd3;
        exp_q.push_back(24'h000000);
        @(negedge clk);
        speed = 2'd0;
        repeat (3) @(negedge clk);
        exp = exp_q.pop_front();
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd} !== exp) begin
            n_fail++; $display("FAIL rollover_time: got %h expected %h", {hour_bcd, min_bcd, sec_bcd}, exp);
        end
        n_chk++;
        if (tick_cnt - t0 != 1) begin
            n_fail++; $display("FAIL rollover_ticks: got %0d expected 1", tick_cnt - t0);
        end
    endtask

    task automatic test_run();
        logic [23:0] exp;
        int t0;
        t0 = tick_cnt;
        @(negedge clk);
        speed = 2'd3;
        exp_q.push_back({bcd(0), bcd(1), bcd(40)});
        repeat (200) @(negedge clk);
        speed = 2'd0;
        repeat (4) @(negedge clk);
        n_chk++;
        if (tick_cnt - t0 != 100) begin
            n_fail++; $display("FAIL run_ticks: got %0d expected 100", tick_cnt - t0);
        end
        exp = exp_q.pop_front();
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd} !== exp) begin
            n_fail++; $display("FAIL run_time: got %h expected %h", {hour_bcd, min_bcd, sec_bcd}, exp);
        end
        n_chk++;
        if (led_bar !== exp_led(40)) begin
            n_fail++; $display("FAIL run_led: got %b expected %b", led_bar, exp_led(40));
        end
    endtask

    task automatic test_sec_edit();
        logic [23:0] exp;
        int t0;
        repeat (3) press(4'b1000);
        n_chk++;
        if (edit_field !== 2'd3 || blink_mask !== 4'b0000) begin
            n_fail++; $display("FAIL sec_mode: got field %0d blink %b expected field 3 blink 0000",
                               edit_field, blink_mask);
        end
        speed = 2'd3;
        t0 = tick_cnt;
        exp_q.push_back({bcd(0), bcd(1), bcd((40 + 61) % 60)});
        repeat (61) press(4'b0100);
        exp = exp_q.pop_front();
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd} !== exp) begin
            n_fail++; $display("FAIL sec_inc: got %h expected %h", {hour_bcd, min_bcd, sec_bcd}, exp);
        end
        n_chk++;
        if (tick_cnt != t0) begin
            n_fail++; $display("FAIL sec_paused: got %0d ticks expected 0", tick_cnt - t0);
        end
        speed = 2'd0;
        press(4'b1000);
    endtask

    task automatic test_window();
        repeat (3) press(4'b0001);
        n_chk++;
        if (win_off !== 2'd2 || dp_mask !== 4'b1010 || disp_digits !== 16'h0141) begin
            n_fail++; $display("FAIL win_right_sat: got off %0d dp %b digits %h expected off 2 dp 1010 digits 0141",
                               win_off, dp_mask, disp_digits);
        end
        press(4'b0010);
        n_chk++;
        if (win_off !== 2'd1 || dp_mask !== 4'b0101 || disp_digits !== 16'h0014) begin
            n_fail++; $display("FAIL win_left: got off %0d dp %b digits %h expected off 1 dp 0101 digits 0014",
                               win_off, dp_mask, disp_digits);
        end
        press(4'b0011);
        n_chk++;
        if (win_off !== 2'd1 || blink_mask !== 4'b0000) begin
            n_fail++; $display("FAIL win_cancel: got off %0d blink %b expected off 1 blink 0000",
                               win_off, blink_mask);
        end
    endtask

    task automatic test_hold();
        logic [7:0] last, e;
        press(4'b1000);
        repeat (20) press(4'b0100);
        n_chk++;
        if (hour_bcd !== 8'h20 || blink_mask !== 4'b1000) begin
            n_fail++; $display("FAIL hold_preset: got hour %h blink %b expected hour 20 blink 1000",
                               hour_bcd, blink_mask);
        end
        // Pulse that falls entirely between two rising edges.
        @(negedge clk);
        #1 btn_inc = 1'b1;
        #2 btn_inc = 1'b0;
        repeat (6) @(negedge clk);
        n_chk++;
        if (hour_bcd !== 8'h20) begin
            n_fail++; $display("FAIL glitch: got hour %h expected 20", hour_bcd);
        end
        // 28 sampled cycles high: accepts at 2 + 5k (k = 0..5) with HOLD = 4.
        foreach (hexp_q[i]) hexp_q.delete(i);
        hexp_q.push_back(8'h21); hexp_q.push_back(8'h22); hexp_q.push_back(8'h23);
        hexp_q.push_back(8'h00); hexp_q.push_back(8'h01); hexp_q.push_back(8'h02);
        last = hour_bcd;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            btn_inc = (c < 28);
            if (hour_bcd !== last) begin
                last = hour_bcd;
                n_chk++;
                if (hexp_q.size() == 0) begin
                    n_fail++; $display("FAIL hold_extra: got hour %h expected no further change", hour_bcd);
                end else begin
                    e = hexp_q.pop_front();
                    if (hour_bcd !== e) begin
                        n_fail++; $display("FAIL hold_step: got hour %h expected %h", hour_bcd, e);
                    end
                end
            end
        end
        n_chk++;
        if (hexp_q.size() != 0 || hour_bcd !== 8'h02) begin
            n_fail++; $display("FAIL hold_count: got hour %h with %0d steps missing expected 02 and 0 missing",
                               hour_bcd, hexp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        press(4'b1000);
        press(4'b0001);
        n_chk++;
        if (edit_field !== 2'd2 || win_off !== 2'd2 || blink_mask !== 4'b1100) begin
            n_fail++; $display("FAIL mid_setup: got field %0d off %0d blink %b expected 2 2 1100",
                               edit_field, win_off, blink_mask);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({hour_bcd, min_bcd, sec_bcd, led_bar} !== 32'h0) begin
            n_fail++; $display("FAIL async_time: got %h expected 00000000", {hour_bcd, min_bcd, sec_bcd, led_bar});
        end
        n_chk++;
        if ({disp_digits, dp_mask, blink_mask, edit_field, win_off, sec_tick} !== 29'h0) begin
            n_fail++; $display("FAIL async_ctrl: got %h expected 0",
                               {disp_digits, dp_mask, blink_mask, edit_field, win_off, sec_tick});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (edit_field !== 2'd0 || win_off !== 2'd0 || dp_mask !== 4'b1010 || hour_bcd !== 8'h00) begin
            n_fail++; $display("FAIL post_reset: got field %0d off %0d dp %b hour %h expected 0 0 1010 00",
                               edit_field, win_off, dp_mask, hour_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_run();
        test_sec_edit();
        test_window();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
